// File: rtl/usb_token_pkg.sv
// usb_token_pkg: shared constants, FSM state type and the serial CRC5 step
// for the USB token receive path.
//   PID_*            4-bit token PID values (PID byte bits [3:0])
//   CRC5_*           CRC5 polynomial, LFSR seed and good-packet residual
//   ERR_*            tok_err_code values
//   token_state_t    receive FSM states
//   crc5_step()      one serial LFSR update: x^5 + x^2 + 1
package usb_token_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_SOF   = 4'b0101;

    localparam logic [4:0] CRC5_POLY     = 5'b00101;
    localparam logic [4:0] CRC5_INIT     = 5'b11111;
    localparam logic [4:0] CRC5_RESIDUAL = 5'b01100;

    localparam logic [1:0] ERR_PID = 2'd0;
    localparam logic [1:0] ERR_CRC = 2'd1;
    localparam logic [1:0] ERR_LEN = 2'd2;

    // Bit positions (running count after the bit) where each field ends.
    localparam int PID_END   = 8;
    localparam int FIELD_END = 19;
    localparam int CRC_END   = 24;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PID   = 3'd1,
        ST_FIELD = 3'd2,
        ST_CRC   = 3'd3,
        ST_DONE  = 3'd4,
        ST_SKIP  = 3'd5
    } token_state_t;

    function automatic logic [4:0] crc5_step(input logic [4:0] q, input logic b);
        logic fb;
        fb = b ^ q[4];
        crc5_step = {q[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
    endfunction

endpackage

// File: rtl/usb_token_rx_if.sv
// usb_token_rx_if: bit stream from the NRZI-decode/unstuff stage plus the
// decoded token results for the device core.
//   rx_sop/rx_bit/rx_bit_valid/rx_eop   serial packet stream into the decoder
//   tok_valid/tok_pid/tok_addr/tok_endp good-token pulse and held fields
//   tok_err/tok_err_code                rejected-packet pulse and held cause
//   sof_valid/sof_frame                 good SOF pulse and frame (SOF_DECODE_EN only)
//   dbg_state                           receive FSM state, for observation only
// Stream semantics: rx_bit is consumed on any cycle rx_bit_valid is high;
// rx_sop and rx_eop are single-cycle strobes with no back-pressure, and a
// bit valid in the rx_sop or rx_eop cycle belongs to that packet.
// Macro: SOF_DECODE_EN adds the SOF result signals.
interface usb_token_rx_if;
    import usb_token_pkg::*;

    logic         rx_sop;
    logic         rx_bit;
    logic         rx_bit_valid;
    logic         rx_eop;
    logic         tok_valid;
    logic [3:0]   tok_pid;
    logic [6:0]   tok_addr;
    logic [3:0]   tok_endp;
    logic         tok_err;
    logic [1:0]   tok_err_code;
    token_state_t dbg_state;
`ifdef SOF_DECODE_EN
    logic         sof_valid;
    logic [10:0]  sof_frame;
`endif

    modport master (
        output rx_sop, rx_bit, rx_bit_valid, rx_eop,
        input  tok_valid, tok_pid, tok_addr, tok_endp, tok_err, tok_err_code,
`ifdef SOF_DECODE_EN
        input  sof_valid, sof_frame,
`endif
        input  dbg_state
    );

    modport slave (
        input  rx_sop, rx_bit, rx_bit_valid, rx_eop,
        output tok_valid, tok_pid, tok_addr, tok_endp, tok_err, tok_err_code,
`ifdef SOF_DECODE_EN
        output sof_valid, sof_frame,
`endif
        output dbg_state
    );

endinterface

// File: rtl/usb_crc5_serial.sv
// usb_crc5_serial: serial CRC5 checker, one bit per enabled cycle.
//   clk, rst  clock, asynchronous active-high reset (LFSR to 5'b11111)
//   clr       reseed the LFSR; if en is also high the bit is applied to the seed
//   en        apply bit_in this cycle
//   bit_in    data bit
//   ok        registered LFSR equals the good-packet residual
//   q         registered LFSR value
module usb_crc5_serial
    import usb_token_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic       ok,
    output logic [4:0] q
);

    logic [4:0] q_r;
    logic [4:0] base;

    always_comb begin
        base = clr ? CRC5_INIT : q_r;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r <= CRC5_INIT;
        end else if (en) begin
            q_r <= crc5_step(base, bit_in);
        end else if (clr) begin
            q_r <= CRC5_INIT;
        end
    end

    assign q  = q_r;
    assign ok = (q_r == CRC5_RESIDUAL);

endmodule

// File: rtl/usb_token_rx.sv
// usb_token_rx: receive-side USB token decoder (OUT/IN/SETUP, optionally SOF).
//   clk, rst  clock, asynchronous active-high reset
//   bus       usb_token_rx_if.slave: serial stream in, decoded token/error out
// Parameters: MAX_BITS (token length in bits), LONG_IS_ERR (1 = bits past
// MAX_BITS before EOP are a length error).
// Macro: SOF_DECODE_EN decodes SOF packets and drives sof_valid/sof_frame.
module usb_token_rx
    import usb_token_pkg::*;
#(
    parameter int MAX_BITS    = 24,
    parameter bit LONG_IS_ERR = 1'b1
) (
    input  logic clk,
    input  logic rst,
    usb_token_rx_if.slave bus
);

    token_state_t state, st_eff, st_nxt;
    logic [5:0]   cnt, cnt_eff, cnt_nxt;
    logic [7:0]   pid_sr, pid_eff, pid_nxt;
    logic [10:0]  fld_sr, fld_eff, fld_nxt;
    logic         pid_err, perr_eff, perr_nxt;
    logic         take, crc_en, crc_pass, crc_ok;
    logic [4:0]   crc_q, crc_base;
    logic         len_err, eop_act, report;

    logic         tok_valid_r, tok_err_r;
    logic [3:0]   tok_pid_r, tok_endp_r;
    logic [6:0]   tok_addr_r;
    logic [1:0]   tok_err_code_r;
`ifdef SOF_DECODE_EN
    logic         sof_valid_r;
    logic [10:0]  sof_frame_r;
`endif

    function automatic logic is_token(input logic [3:0] p);
        is_token = (p == PID_OUT) || (p == PID_IN) || (p == PID_SETUP)
`ifdef SOF_DECODE_EN
                   || (p == PID_SOF)
`endif
                   ;
    endfunction

    usb_crc5_serial u_crc (
        .clk    (clk),
        .rst    (rst),
        .clr    (bus.rx_sop),
        .en     (crc_en),
        .bit_in (bus.rx_bit),
        .ok     (crc_ok),
        .q      (crc_q)
    );

    // The "_eff" values are the state as seen by this cycle's bit: rx_sop
    // restarts the packet first so a bit in the same cycle is bit 0.
    // The "_nxt" values include this cycle's bit, so an EOP in the same
    // cycle as the last bit is judged on the complete packet.
    always_comb begin
        st_eff   = bus.rx_sop ? ST_PID : state;
        cnt_eff  = bus.rx_sop ? 6'd0 : cnt;
        pid_eff  = bus.rx_sop ? 8'd0 : pid_sr;
        fld_eff  = bus.rx_sop ? 11'd0 : fld_sr;
        perr_eff = bus.rx_sop ? 1'b0 : pid_err;
        crc_base = bus.rx_sop ? CRC5_INIT : crc_q;

        take    = bus.rx_bit_valid && (st_eff != ST_IDLE);
        cnt_nxt = (take && (cnt_eff != 6'h3F)) ? cnt_eff + 6'd1 : cnt_eff;
        pid_nxt = (take && st_eff == ST_PID)   ? {bus.rx_bit, pid_eff[7:1]} : pid_eff;
        fld_nxt = (take && st_eff == ST_FIELD) ? {bus.rx_bit, fld_eff[10:1]} : fld_eff;
        crc_en  = take && (st_eff == ST_FIELD || st_eff == ST_CRC);
        crc_pass = crc_en ? (crc5_step(crc_base, bus.rx_bit) == CRC5_RESIDUAL)
                          : (!bus.rx_sop && crc_ok);

        st_nxt   = st_eff;
        perr_nxt = perr_eff;
        if (take) begin
            case (st_eff)
                ST_PID: begin
                    if (cnt_nxt == 6'(PID_END)) begin
                        if (pid_nxt[7:4] != ~pid_nxt[3:0]) begin
                            st_nxt   = ST_SKIP;
                            perr_nxt = 1'b1;
                        end else if (is_token(pid_nxt[3:0])) begin
                            st_nxt = ST_FIELD;
                        end else begin
                            st_nxt = ST_SKIP;
                        end
                    end
                end
                ST_FIELD: if (cnt_nxt == 6'(FIELD_END)) st_nxt = ST_CRC;
                ST_CRC:   if (cnt_nxt == 6'(CRC_END))   st_nxt = ST_DONE;
                default: ;
            endcase
        end

        len_err = (cnt_nxt < 6'(MAX_BITS)) || (LONG_IS_ERR && (cnt_nxt > 6'(MAX_BITS)));
        eop_act = bus.rx_eop && (st_eff != ST_IDLE);
        // A non-token with a good PID complement is dropped without a report.
        report  = eop_act && !(st_nxt == ST_SKIP && !perr_nxt);
        if (eop_act) st_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            cnt            <= 6'd0;
            pid_sr         <= 8'd0;
            fld_sr         <= 11'd0;
            pid_err        <= 1'b0;
            tok_valid_r    <= 1'b0;
            tok_err_r      <= 1'b0;
            tok_pid_r      <= 4'd0;
            tok_addr_r     <= 7'd0;
            tok_endp_r     <= 4'd0;
            tok_err_code_r <= 2'd0;
`ifdef SOF_DECODE_EN
            sof_valid_r    <= 1'b0;
            sof_frame_r    <= 11'd0;
`endif
        end else begin
            state       <= st_nxt;
            cnt         <= cnt_nxt;
            pid_sr      <= pid_nxt;
            fld_sr      <= fld_nxt;
            pid_err     <= perr_nxt;
            tok_valid_r <= 1'b0;
            tok_err_r   <= 1'b0;
`ifdef SOF_DECODE_EN
            sof_valid_r <= 1'b0;
`endif
            if (report) begin
                if (len_err) begin
                    tok_err_r      <= 1'b1;
                    tok_err_code_r <= ERR_LEN;
                end else if (perr_nxt) begin
                    tok_err_r      <= 1'b1;
                    tok_err_code_r <= ERR_PID;
                end else if (!crc_pass) begin
                    tok_err_r      <= 1'b1;
                    tok_err_code_r <= ERR_CRC;
`ifdef SOF_DECODE_EN
                end else if (pid_nxt[3:0] == PID_SOF) begin
                    sof_valid_r <= 1'b1;
                    sof_frame_r <= fld_nxt;
`endif
                end else begin
                    tok_valid_r <= 1'b1;
                    tok_pid_r   <= pid_nxt[3:0];
                    tok_addr_r  <= fld_nxt[6:0];
                    tok_endp_r  <= fld_nxt[10:7];
                end
            end
        end
    end

    assign bus.tok_valid    = tok_valid_r;
    assign bus.tok_err      = tok_err_r;
    assign bus.tok_pid      = tok_pid_r;
    assign bus.tok_addr     = tok_addr_r;
    assign bus.tok_endp     = tok_endp_r;
    assign bus.tok_err_code = tok_err_code_r;
    assign bus.dbg_state    = state;
`ifdef SOF_DECODE_EN
    assign bus.sof_valid    = sof_valid_r;
    assign bus.sof_frame    = sof_frame_r;
`endif

endmodule

// File: tb/tb_usb_token_rx.sv
// tb_usb_token_rx: directed self-checking bench for usb_token_rx.
// Packets are built as bit vectors (PID LSB first, field LSB first, CRC5
// MSB first) and driven one bit per cycle; results are checked on the
// falling edge after the EOP cycle and one cycle later for pulse width.
module tb_usb_token_rx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    usb_token_rx_if bus ();

    usb_token_rx #(.MAX_BITS(24), .LONG_IS_ERR(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Token CRC generator: seed 11111 over the 11 field bits, result inverted.
    function automatic logic [4:0] crc5_gen(input logic [10:0] fld);
        logic [4:0] q;
        logic       fb;
        q = 5'b11111;
        for (int i = 0; i < 11; i++) begin
            fb = fld[i] ^ q[4];
            q  = {q[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
        end
        crc5_gen = ~q;
    endfunction

    function automatic logic [31:0] mk_pkt(input logic [7:0] pid, input logic [10:0] fld,
                                           input logic [4:0] crc);
        logic [31:0] v;
        v        = 32'($urandom);
        v[7:0]   = pid;
        v[18:8]  = fld;
        for (int k = 0; k < 5; k++) v[19+k] = crc[4-k];
        mk_pkt = v;
    endfunction

    // eop_last: EOP shares the cycle of the final bit; send_eop=0 leaves the
    // packet open.
    task automatic drive_pkt(input logic [31:0] vec, input int nbits,
                             input bit eop_last, input bit send_eop);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            bus.rx_sop       = (i == 0);
            bus.rx_bit_valid = 1'b1;
            bus.rx_bit       = vec[i];
            bus.rx_eop       = send_eop && eop_last && (i == nbits - 1);
        end
        if (send_eop && !eop_last) begin
            @(negedge clk);
            bus.rx_sop       = 1'b0;
            bus.rx_bit_valid = 1'b0;
            bus.rx_bit       = 1'b0;
            bus.rx_eop       = 1'b1;
        end
        @(negedge clk);
        bus.rx_sop       = 1'b0;
        bus.rx_bit_valid = 1'b0;
        bus.rx_bit       = 1'b0;
        bus.rx_eop       = 1'b0;
    endtask

    task automatic next_cycle_quiet(input string tag);
        @(negedge clk);
        chk({tag, "_valid_drop"}, 32'(bus.tok_valid), 32'd0);
        chk({tag, "_err_drop"},   32'(bus.tok_err),   32'd0);
    endtask

    logic [31:0] v;

    initial begin
        bus.rx_sop = 1'b0; bus.rx_bit = 1'b0; bus.rx_bit_valid = 1'b0; bus.rx_eop = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(bus.tok_valid),    32'd0);
        chk("rst_err",   32'(bus.tok_err),      32'd0);
        chk("rst_pid",   32'(bus.tok_pid),      32'd0);
        chk("rst_addr",  32'(bus.tok_addr),     32'd0);
        chk("rst_endp",  32'(bus.tok_endp),     32'd0);
        chk("rst_code",  32'(bus.tok_err_code), 32'd0);
        chk("rst_state", 32'(bus.dbg_state),    32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // IN, addr 15h endp Eh, CRC5 = 10111 (hand computed), EOP after last bit
        v = mk_pkt(8'h69, {4'hE, 7'h15}, 5'b10111);
        drive_pkt(v, 24, 1'b0, 1'b1);
        chk("in_valid", 32'(bus.tok_valid), 32'd1);
        chk("in_err",   32'(bus.tok_err),   32'd0);
        chk("in_pid",   32'(bus.tok_pid),   32'h9);
        chk("in_addr",  32'(bus.tok_addr),  32'h15);
        chk("in_endp",  32'(bus.tok_endp),  32'hE);
        next_cycle_quiet("in");

        // Same packet, CRC bit 2 flipped, EOP with the last bit
        v = mk_pkt(8'h69, {4'hE, 7'h15}, 5'b10011);
        drive_pkt(v, 24, 1'b1, 1'b1);
        chk("crc_err",   32'(bus.tok_err),      32'd1);
        chk("crc_code",  32'(bus.tok_err_code), 32'd1);
        chk("crc_valid", 32'(bus.tok_valid),    32'd0);
        chk("crc_addr",  32'(bus.tok_addr),     32'h15);
        next_cycle_quiet("crc");
        chk("crc_code_hold", 32'(bus.tok_err_code), 32'd1);

        // Bad PID complement, full length
        v = mk_pkt(8'h11, 11'h123, 5'b00000);
        drive_pkt(v, 24, 1'b0, 1'b1);
        chk("pid_err",  32'(bus.tok_err),      32'd1);
        chk("pid_code", 32'(bus.tok_err_code), 32'd0);
        next_cycle_quiet("pid");

        // SETUP truncated at 20 bits
        v = mk_pkt(8'h2D, {4'h3, 7'h05}, crc5_gen({4'h3, 7'h05}));
        drive_pkt(v, 20, 1'b0, 1'b1);
        chk("short_err",  32'(bus.tok_err),      32'd1);
        chk("short_code", 32'(bus.tok_err_code), 32'd2);
        chk("short_pid",  32'(bus.tok_pid),      32'h9);
        next_cycle_quiet("short");

        // Bad-PID packet cut short: length outranks PID
        v = mk_pkt(8'h11, 11'h123, 5'b00000);
        drive_pkt(v, 12, 1'b0, 1'b1);
        chk("prio_code", 32'(bus.tok_err_code), 32'd2);

        // SETUP with 26 bits
        drive_pkt(v & 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
        v = mk_pkt(8'h2D, {4'h3, 7'h05}, crc5_gen({4'h3, 7'h05}));
        drive_pkt(v, 26, 1'b1, 1'b1);
        chk("long_err",  32'(bus.tok_err),      32'd1);
        chk("long_code", 32'(bus.tok_err_code), 32'd2);
        next_cycle_quiet("long");

        // Set code to CRC so the ACK check below proves it is held
        v = mk_pkt(8'hE1, {4'h1, 7'h3A}, ~crc5_gen({4'h1, 7'h3A}));
        drive_pkt(v, 24, 1'b0, 1'b1);
        chk("out_crc_code", 32'(bus.tok_err_code), 32'd1);

        // ACK handshake: silent
        v = mk_pkt(8'hD2, 11'h000, 5'b00000);
        drive_pkt(v, 8, 1'b0, 1'b1);
        chk("ack_valid", 32'(bus.tok_valid),    32'd0);
        chk("ack_err",   32'(bus.tok_err),      32'd0);
        chk("ack_code",  32'(bus.tok_err_code), 32'd1);
        chk("ack_state", 32'(bus.dbg_state),    32'd0);

        // Restart mid-FIELD, then a good OUT
        v = mk_pkt(8'h2D, {4'h7, 7'h44}, 5'b11111);
        drive_pkt(v, 12, 1'b0, 1'b0);
        v = mk_pkt(8'hE1, {4'h1, 7'h3A}, crc5_gen({4'h1, 7'h3A}));
        drive_pkt(v, 24, 1'b1, 1'b1);
        chk("rs_valid", 32'(bus.tok_valid), 32'd1);
        chk("rs_err",   32'(bus.tok_err),   32'd0);
        chk("rs_pid",   32'(bus.tok_pid),   32'h1);
        chk("rs_addr",  32'(bus.tok_addr),  32'h3A);
        chk("rs_endp",  32'(bus.tok_endp),  32'h1);
        next_cycle_quiet("rs");

        // Reset in the middle of the CRC field
        v = mk_pkt(8'h69, {4'h2, 7'h11}, crc5_gen({4'h2, 7'h11}));
        drive_pkt(v, 21, 1'b0, 1'b0);
        chk("midcrc_state", 32'(bus.dbg_state), 32'd3);
        rst = 1'b1;
        #1;
        chk("arst_pid",   32'(bus.tok_pid),      32'd0);
        chk("arst_addr",  32'(bus.tok_addr),     32'd0);
        chk("arst_endp",  32'(bus.tok_endp),     32'd0);
        chk("arst_code",  32'(bus.tok_err_code), 32'd0);
        chk("arst_state", 32'(bus.dbg_state),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        v = mk_pkt(8'h2D, {4'hF, 7'h7F}, crc5_gen({4'hF, 7'h7F}));
        drive_pkt(v, 24, 1'b0, 1'b1);
        chk("post_valid", 32'(bus.tok_valid), 32'd1);
        chk("post_pid",   32'(bus.tok_pid),   32'hD);
        chk("post_addr",  32'(bus.tok_addr),  32'h7F);
        chk("post_endp",  32'(bus.tok_endp),  32'hF);
        next_cycle_quiet("post");

        // SOF frame 2A5h
        v = mk_pkt(8'hA5, 11'h2A5, crc5_gen(11'h2A5));
        drive_pkt(v, 24, 1'b0, 1'b1);
`ifdef SOF_DECODE_EN
        chk("sof_valid", 32'(bus.sof_valid), 32'd1);
        chk("sof_frame", 32'(bus.sof_frame), 32'h2A5);
        chk("sof_tokv",  32'(bus.tok_valid), 32'd0);
        chk("sof_err",   32'(bus.tok_err),   32'd0);
        chk("sof_addr",  32'(bus.tok_addr),  32'h7F);
        @(negedge clk);
        chk("sof_drop",  32'(bus.sof_valid), 32'd0);
`else
        chk("sof_tokv", 32'(bus.tok_valid), 32'd0);
        chk("sof_err",  32'(bus.tok_err),   32'd0);
        chk("sof_addr", 32'(bus.tok_addr),  32'h7F);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
